// File: rtl/uc_multiciclo.sv
// Multi-cycle control unit for the RV64 subset datapath: sequences
// FETCH/DECODE/EXEC/MEM/WB, with memory ready handshakes, wait watchdog, sticky trap and retire counter.
//
// state  | meaning
// FETCH  | wait for instruction word, latch IR on i_mem_ready
// DECODE | capture opcode, reject illegal encodings
// EXEC   | drive ALU; branches resolve and retire here
// MEM    | data read/write request held until d_mem_ready
// WB     | register write-back, PC+4, retire
// TRAP   | sticky fault, all enables off until reset
module uc_multiciclo #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic [3:0]       alu_flags,
   input  logic             i_mem_ready,
   input  logic             d_mem_ready,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_src,
   output logic [3:0]       alu_cmd,
   output logic             alu_src,
   output logic             rf_we,
   output logic             rf_src,
   output logic             d_mem_re,
   output logic             d_mem_we,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] retired
);

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_S  = 7'b0100011;
   localparam logic [6:0] OP_B  = 7'b1100011;
   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

   state_t           state, state_nx;
   logic [6:0]       op_q;
   logic [7:0]       wait_cnt, wait_nx;
   logic [1:0]       cause_q, cause_nx;
   logic [CNT_W-1:0] ret_q;
   logic             retire;
   logic             taken;
   logic             unused_flags;

   assign unused_flags = ^alu_flags[3:1];
   assign taken = ((funct3 == 3'b000) &&  alu_flags[0]) ||
                  ((funct3 == 3'b001) && !alu_flags[0]);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= FETCH;
         op_q     <= '0;
         wait_cnt <= '0;
         cause_q  <= '0;
         ret_q    <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_nx;
         cause_q  <= cause_nx;
         if (state == DECODE) op_q <= opcode;
         if (retire) ret_q <= ret_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_comb begin
      state_nx = state;
      wait_nx  = wait_cnt;
      cause_nx = cause_q;
      retire   = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_src   = 1'b0;
      alu_cmd  = 4'b0000;
      alu_src  = 1'b0;
      rf_we    = 1'b0;
      rf_src   = 1'b0;
      d_mem_re = 1'b0;
      d_mem_we = 1'b0;
      trap     = 1'b0;

      // ALU controls stay stable from EXEC through MEM and WB
      if (state == EXEC || state == MEM || state == WB) begin
         case (op_q)
            OP_I:       begin alu_cmd = 4'b0001; alu_src = 1'b1; end
            OP_LD, OP_S: begin alu_cmd = 4'b0010; alu_src = 1'b1; end
            OP_B:       alu_cmd = 4'b0011;
            default:    ;
         endcase
      end

      case (state)
         FETCH: begin
            ir_we = i_mem_ready;
            if (i_mem_ready) begin
               state_nx = DECODE;
               wait_nx  = '0;
            end else if (wait_cnt >= WAIT_LAST) begin
               state_nx = TRAP;
               cause_nx = 2'b10;
            end else begin
               wait_nx = wait_cnt + 8'd1;
            end
         end
         DECODE: begin
            case (opcode)
               OP_R, OP_I, OP_LD, OP_S, OP_B: state_nx = EXEC;
               default: begin
                  state_nx = TRAP;
                  cause_nx = 2'b01;
               end
            endcase
         end
         EXEC: begin
            case (op_q)
               OP_R, OP_I:  state_nx = WB;
               OP_LD, OP_S: state_nx = MEM;
               OP_B: begin
                  pc_we    = 1'b1;
                  pc_src   = taken;
                  retire   = 1'b1;
                  state_nx = FETCH;
               end
               default: state_nx = TRAP;
            endcase
         end
         MEM: begin
            d_mem_re = (op_q == OP_LD);
            d_mem_we = (op_q == OP_S);
            if (d_mem_ready) begin
               wait_nx = '0;
               if (op_q == OP_S) begin
                  pc_we    = 1'b1;
                  retire   = 1'b1;
                  state_nx = FETCH;
               end else begin
                  state_nx = WB;
               end
            end else if (wait_cnt >= WAIT_LAST) begin
               state_nx = TRAP;
               cause_nx = 2'b11;
            end else begin
               wait_nx = wait_cnt + 8'd1;
            end
         end
         WB: begin
            rf_we    = 1'b1;
            rf_src   = (op_q == OP_LD);
            pc_we    = 1'b1;
            retire   = 1'b1;
            state_nx = FETCH;
         end
         TRAP: trap = 1'b1;
         default: state_nx = FETCH;
      endcase

      // reset forces every output low in the same cycle it is asserted
      if (reset) begin
         ir_we    = 1'b0;
         pc_we    = 1'b0;
         pc_src   = 1'b0;
         alu_cmd  = 4'b0000;
         alu_src  = 1'b0;
         rf_we    = 1'b0;
         rf_src   = 1'b0;
         d_mem_re = 1'b0;
         d_mem_we = 1'b0;
         trap     = 1'b0;
      end
   end

   assign trap_cause = reset ? 2'b00 : cause_q;
   assign retired    = reset ? '0 : ret_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Randomized bench for uc_multiciclo: an instruction-level model expands each
// instruction into its expected per-cycle output vectors, which are then replayed against the DUT.
module tb_uc_multiciclo;
   localparam int TO = 15;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_S  = 7'b0100011;
   localparam logic [6:0] OP_B  = 7'b1100011;

   logic        clk = 1'b1;
   logic        reset;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [3:0]  alu_flags;
   logic        i_mem_ready, d_mem_ready;
   logic        ir_we, pc_we, pc_src, alu_src, rf_we, rf_src;
   logic        d_mem_re, d_mem_we, trap;
   logic [3:0]  alu_cmd;
   logic [1:0]  trap_cause;
   logic [15:0] retired;

   uc_multiciclo #(.CNT_W(16), .MEM_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
      .alu_flags(alu_flags), .i_mem_ready(i_mem_ready), .d_mem_ready(d_mem_ready),
      .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_cmd(alu_cmd),
      .alu_src(alu_src), .rf_we(rf_we), .rf_src(rf_src), .d_mem_re(d_mem_re),
      .d_mem_we(d_mem_we), .trap(trap), .trap_cause(trap_cause), .retired(retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        zero;
      logic        imr;
      logic        dmr;
      logic [14:0] exp;
      logic [15:0] ret;
   } cyc_t;

   cyc_t        q[$];
   logic [15:0] r_cnt = '0;
   logic [6:0]  cur_op = '0;
   logic [2:0]  cur_f3 = '0;
   logic        cur_zero = 1'b0;
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc_idx = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc_idx, obs, exp);
      end
   endtask

   function automatic logic rb();
      return logic'($urandom % 2);
   endfunction

   // {ir_we, pc_we, pc_src, alu_cmd, alu_src, rf_we, rf_src, d_mem_re, d_mem_we, trap, trap_cause}
   function automatic logic [14:0] ev(input logic ir, pcw, pcs, input logic [3:0] cmd,
                                      input logic src, rfw, rfs, re, we, tr, input logic [1:0] tc);
      return {ir, pcw, pcs, cmd, src, rfw, rfs, re, we, tr, tc};
   endfunction

   function automatic void push(input logic rst, imr, dmr, input logic [14:0] e);
      cyc_t c;
      c.rst = rst; c.opc = cur_op; c.f3 = cur_f3; c.zero = cur_zero;
      c.imr = imr; c.dmr = dmr; c.exp = e; c.ret = r_cnt;
      q.push_back(c);
   endfunction

   function automatic void do_reset();
      r_cnt = '0;
      push(1'b1, rb(), rb(), 15'd0);
   endfunction

   function automatic void go_trap(input logic [1:0] cause, input int n);
      repeat (n) push(1'b0, rb(), rb(), ev(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 1, cause));
      do_reset();
   endfunction

   function automatic logic legal(input logic [6:0] o);
      return (o == OP_R) || (o == OP_I) || (o == OP_LD) || (o == OP_S) || (o == OP_B);
   endfunction

   // expand one instruction into its expected cycles; abort>0 resets after that many MEM wait cycles
   function automatic void gen_instr(input logic [6:0] opc, input logic [2:0] f3, input logic zero,
                                     input int fw, input int mw, input int abort);
      logic [3:0] cmd;
      logic       src, is_ld, is_s, taken;
      cur_op = opc; cur_f3 = f3; cur_zero = zero;
      for (int i = 0; i < fw && i < TO; i++) push(1'b0, 1'b0, rb(), 15'd0);
      if (fw >= TO) begin go_trap(2'b10, $urandom_range(3, 20)); return; end
      push(1'b0, 1'b1, rb(), ev(1, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 2'b00));
      push(1'b0, rb(), rb(), 15'd0);
      if (!legal(opc)) begin go_trap(2'b01, 20); return; end
      is_ld = (opc == OP_LD);
      is_s  = (opc == OP_S);
      cmd   = (opc == OP_R) ? 4'd0 : (opc == OP_I) ? 4'd1 : (opc == OP_B) ? 4'd3 : 4'd2;
      src   = (opc == OP_I) || is_ld || is_s;
      if (opc == OP_B) begin
         taken = ((f3 == 3'd0) && zero) || ((f3 == 3'd1) && !zero);
         push(1'b0, rb(), rb(), ev(0, 1, taken, cmd, 0, 0, 0, 0, 0, 0, 2'b00));
         r_cnt = r_cnt + 16'd1;
         return;
      end
      push(1'b0, rb(), rb(), ev(0, 0, 0, cmd, src, 0, 0, 0, 0, 0, 2'b00));
      if (is_ld || is_s) begin
         for (int i = 0; i < mw && i < TO; i++) begin
            push(1'b0, rb(), 1'b0, ev(0, 0, 0, cmd, src, 0, 0, is_ld, is_s, 0, 2'b00));
            if (abort > 0 && i + 1 == abort) begin do_reset(); return; end
         end
         if (mw >= TO) begin go_trap(2'b11, $urandom_range(3, 20)); return; end
         if (is_s) begin
            push(1'b0, rb(), 1'b1, ev(0, 1, 0, cmd, src, 0, 0, 0, 1, 0, 2'b00));
            r_cnt = r_cnt + 16'd1;
            return;
         end
         push(1'b0, rb(), 1'b1, ev(0, 0, 0, cmd, src, 0, 0, 1, 0, 0, 2'b00));
      end
      push(1'b0, rb(), rb(), ev(0, 1, 0, cmd, src, 1, is_ld, 0, 0, 0, 2'b00));
      r_cnt = r_cnt + 16'd1;
   endfunction

   initial begin
      logic [6:0] ops [5];
      logic [6:0] o;
      int fw, mw, ab;
      cyc_t c;
      ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LD; ops[3] = OP_S; ops[4] = OP_B;

      do_reset();
      do_reset();
      gen_instr(OP_R, 3'd0, 1'b0, 0, 0, 0);
      gen_instr(OP_LD, 3'd3, 1'b0, 0, 3, 0);
      gen_instr(OP_B, 3'd0, 1'b1, 0, 0, 0);
      gen_instr(OP_B, 3'd1, 1'b1, 0, 0, 0);
      gen_instr(7'b1111111, 3'd0, 1'b0, 0, 0, 0);
      gen_instr(OP_S, 3'd3, 1'b0, 0, TO, 0);
      gen_instr(OP_I, 3'd0, 1'b0, 2, 0, 0);
      gen_instr(OP_LD, 3'd3, 1'b0, 0, 5, 2);
      gen_instr(OP_R, 3'd0, 1'b0, 0, 0, 0);
      gen_instr(OP_R, 3'd0, 1'b0, TO, 0, 0);

      for (int n = 0; n < 250; n++) begin
         if ($urandom_range(0, 19) == 0) begin
            do o = 7'($urandom); while (legal(o));
         end else begin
            o = ops[$urandom_range(0, 4)];
         end
         fw = ($urandom_range(0, 24) == 0) ? TO : $urandom_range(0, 3);
         mw = ($urandom_range(0, 14) == 0) ? TO : $urandom_range(0, 4);
         ab = ($urandom_range(0, 9) == 0 && mw > 0 && mw < TO) ? $urandom_range(1, mw) : 0;
         gen_instr(o, 3'($urandom), rb(), fw, mw, ab);
      end

      for (int k = 0; k < q.size(); k++) begin
         c = q[k];
         cyc_idx     = k;
         reset       = c.rst;
         opcode      = c.opc;
         funct3      = c.f3;
         alu_flags   = {1'b0, rb(), rb(), c.zero};
         i_mem_ready = c.imr;
         d_mem_ready = c.dmr;
         @(negedge clk);
         check("outputs", 32'({ir_we, pc_we, pc_src, alu_cmd, alu_src, rf_we, rf_src,
                               d_mem_re, d_mem_we, trap, trap_cause}), 32'(c.exp));
         check("retired", 32'(retired), 32'(c.ret));
         check("rf_we_and_d_mem_we", 32'(rf_we & d_mem_we), 32'd0);
         @(posedge clk);
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/uc_multiciclo.md
Name: uc_multiciclo

Overview:
- Multi-cycle control unit that sequences the RV64 subset datapath (PC register, register file, ALU, instruction and data memories).
- Latches the opcode, steps each instruction through FETCH/DECODE/EXEC/MEM/WB, and drives every datapath enable and mux select.
- Adds memory ready handshakes, a memory-wait watchdog, a sticky trap, and a retired-instruction counter.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- MEM_TIMEOUT, 15, maximum cycles in FETCH or MEM waiting for ready before trap (1..255).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  7  instruction bits [6:0] from the datapath.
- funct3  in  3  instruction bits [14:12].
- alu_flags  in  4  [0]=zero, [1]=negative, [2]=borrow, [3]=0.
- i_mem_ready  in  1  instruction word valid this cycle.
- d_mem_ready  in  1  data access complete this cycle.
- ir_we  out  1  latch instruction word.
- pc_we  out  1  PC load enable.
- pc_src  out  1  0: PC+4, 1: PC+imm.
- alu_cmd  out  4  R=0000, I=0001, S=0010, SB=0011.
- alu_src  out  1  0: rs2, 1: imm.
- rf_we  out  1  register file write enable.
- rf_src  out  1  0: ALU, 1: data memory.
- d_mem_re  out  1  data memory read request.
- d_mem_we  out  1  data memory write request.
- trap  out  1  sticky fault.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 fetch timeout, 11 data timeout.
- retired  out  CNT_W  instructions completed.

Behaviour:
- Reset (synchronous, wins over everything, including mid-wait or TRAP):
  - State goes to FETCH; op_q, wait counter, retired and trap_cause clear to 0.
  - All outputs are 0.
- Decoded opcodes:
  - R = 0110011
  - I-ALU = 0010011
  - LD = 0000011
  - S = 0100011
  - B = 1100011
  - Any other opcode is illegal.
- Outputs are decoded from the state register and op_q. Each enable is asserted only in the states listed below. alu_cmd and alu_src hold their EXEC values through MEM and WB so the ALU result stays stable.
- FETCH:
  - ir_we = i_mem_ready.
  - On ready, go to DECODE and clear the wait counter.
  - Otherwise increment the wait counter. When it reaches MEM_TIMEOUT, go to TRAP with cause 10.
- DECODE:
  - op_q <= opcode.
  - Legal opcode: go to EXEC. Illegal: go to TRAP with cause 01.
  - No enables asserted.
- EXEC:
  - R: alu_cmd=R, alu_src=0, then go to WB.
  - I-ALU: alu_cmd=I, alu_src=1, then go to WB.
  - LD and S: alu_cmd=S, alu_src=1, then go to MEM.
  - B: alu_cmd=SB, alu_src=0.
    - taken = (funct3==000 & zero) | (funct3==001 & ~zero). Any other funct3 is not taken.
    - Assert pc_we=1, pc_src=taken, increment retired, go to FETCH.
- MEM:
  - LD: d_mem_re=1 until d_mem_ready; on ready, go to WB.
  - S: d_mem_we=1 until d_mem_ready; on ready (same cycle), assert pc_we=1, pc_src=0, increment retired, go to FETCH.
  - Wait counter as in FETCH. Timeout goes to TRAP with cause 11, and the request deasserts on the next cycle.
- WB:
  - rf_we=1, rf_src=(op_q==LD), pc_we=1, pc_src=0.
  - Increment retired, go to FETCH.
- TRAP:
  - trap=1, every enable 0, trap_cause held.
  - Stays in TRAP until reset.
- Latency:
  - R / I-ALU: 4 cycles.
  - LD: 5 cycles.
  - S: 4 cycles.
  - B: 3 cycles.
  - Each cycle of ready low adds one cycle.
- Other rules:
  - retired wraps modulo 2^CNT_W.
  - At most one pc_we pulse per instruction.
  - rf_we and d_mem_we are never high in the same cycle.
  - The wait counter saturates and never wraps.

Test Plan:
- R add, ready tied high: opcode=0110011 -> ir_we at cycle 0, rf_we=1 with rf_src=0 and pc_we=1 at cycle 3; retired 0->1; alu_cmd=0000 in cycles 2-3.
- LD with d_mem_ready low 3 cycles: opcode=0000011 -> d_mem_re high for 4 MEM cycles, then WB with rf_src=1 and rf_we=1; 8 cycles total; d_mem_we never high.
- BEQ zero=1 then BNE zero=1: funct3=000 -> pc_we=1, pc_src=1 at cycle 2; funct3=001 -> pc_we=1, pc_src=0; no rf_we in either case.
- Illegal opcode 1111111 -> trap=1, trap_cause=01 from cycle 2; all enables 0 for 20 cycles; reset high for 1 cycle -> FETCH, trap=0.
- S with d_mem_ready held low, MEM_TIMEOUT=15 -> d_mem_we high 15 cycles, then trap_cause=11 and d_mem_we=0; retired unchanged.
- Reset asserted during LD MEM wait -> next cycle all outputs 0, state FETCH, retired=0; a following R instruction completes normally.
